// File: rtl/seven_segment_display.sv
// seven_segment_display
// Registered BCD-to-seven-segment decoder for one digit of the parking
// free-space display. Codes 10-15 show a dash. COMMON_ANODE selects the
// output polarity. All segment drives come straight from one 7-bit register,
// so no combinational path runs from the code inputs to the pins.
module seven_segment_display #(
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic led_a,
  output logic led_b,
  output logic led_c,
  output logic led_d,
  output logic led_e,
  output logic led_f,
  output logic led_g
);

  // All-off pattern in the selected polarity
  localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'b1111111 : 7'b0000000;

  // Active-high segment pattern {a,b,c,d,e,f,g} for a BCD code
  function automatic logic [6:0] decode_bcd(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b1111110;
      4'd1:    pat = 7'b0110000;
      4'd2:    pat = 7'b1101101;
      4'd3:    pat = 7'b1111001;
      4'd4:    pat = 7'b0110011;
      4'd5:    pat = 7'b1011011;
      4'd6:    pat = 7'b1011111;
      4'd7:    pat = 7'b1110000;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1111011;
      default: pat = 7'b0000001;  // out-of-range: dash
    endcase
    return pat;
  endfunction

  // Map active-high pattern onto the pin polarity of the display
  function automatic logic [6:0] apply_polarity(input logic [6:0] pat);
    return COMMON_ANODE ? ~pat : pat;
  endfunction

  logic [3:0] code;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  assign code = {A, B, C, D};

  // Next segment pattern from the code present at this edge
  always_comb begin
    seg_d = apply_polarity(decode_bcd(code));
  end

  // Output register; reset forces the display dark immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign {led_a, led_b, led_c, led_d, led_e, led_f, led_g} = seg_q;

endmodule

// File: tb/tb_seven_segment_display.sv
// Bench for seven_segment_display: common-cathode and common-anode builds
// share the same code inputs and are compared against a digit table model.
module tb_seven_segment_display;

  logic clk;
  logic rst_n;
  logic A, B, C, D;

  logic cc_a, cc_b, cc_c, cc_d, cc_e, cc_f, cc_g;
  logic ca_a, ca_b, ca_c, ca_d, ca_e, ca_f, ca_g;

  int vectors;
  int miscompares;

  seven_segment_display #(.COMMON_ANODE(1'b0)) dut_cc (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
    .led_a(cc_a), .led_b(cc_b), .led_c(cc_c), .led_d(cc_d),
    .led_e(cc_e), .led_f(cc_f), .led_g(cc_g)
  );

  seven_segment_display #(.COMMON_ANODE(1'b1)) dut_ca (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
    .led_a(ca_a), .led_b(ca_b), .led_c(ca_c), .led_d(ca_d),
    .led_e(ca_e), .led_f(ca_f), .led_g(ca_g)
  );

  logic [6:0] seg_cc;
  logic [6:0] seg_ca;
  assign seg_cc = {cc_a, cc_b, cc_c, cc_d, cc_e, cc_f, cc_g};
  assign seg_ca = {ca_a, ca_b, ca_c, ca_d, ca_e, ca_f, ca_g};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: which segments a digit lights, as listed for the display
  function automatic logic [6:0] model_lit(input int n);
    logic [6:0] table_q [10];
    table_q[0] = 7'b1111110; table_q[1] = 7'b0110000;
    table_q[2] = 7'b1101101; table_q[3] = 7'b1111001;
    table_q[4] = 7'b0110011; table_q[5] = 7'b1011011;
    table_q[6] = 7'b1011111; table_q[7] = 7'b1110000;
    table_q[8] = 7'b1111111; table_q[9] = 7'b1111011;
    if (n >= 0 && n <= 9) return table_q[n];
    return 7'b0000001;
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check both builds against the model for a given digit
  task automatic check_both(input string tag, input int n);
    check({tag, "_cc"}, seg_cc, model_lit(n));
    check({tag, "_ca"}, seg_ca, ~model_lit(n));
  endtask

  task automatic check_off(input string tag);
    check({tag, "_cc"}, seg_cc, 7'b0000000);
    check({tag, "_ca"}, seg_ca, 7'b1111111);
  endtask

  task automatic set_code(input logic [3:0] n);
    {A, B, C, D} = n;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1;
    set_code(4'd8);

    // Asynchronous reset with no clock edge yet
    #1 rst_n = 1'b0;
    #1 check_off("reset_async");
    tick;
    check_off("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_off("reset_release");
    tick;
    check("first_edge_8_cc", seg_cc, 7'b1111111);
    check("first_edge_8_ca", seg_ca, 7'b0000000);

    // Sweep digits 0-9, one clock each
    for (int n = 0; n <= 9; n++) begin
      @(negedge clk);
      set_code(4'(n));
      tick;
      check_both($sformatf("sweep_%0d", n), n);
      if (n == 0) check("lit_0", seg_cc, 7'b1111110);
      if (n == 1) check("lit_1", seg_cc, 7'b0110000);
      if (n == 2) check("lit_2", seg_cc, 7'b1101101);
      if (n == 7) check("lit_7", seg_cc, 7'b1110000);
      if (n == 9) check("lit_9", seg_cc, 7'b1111011);
      if (n == 1) check("ca_lit_1", seg_ca, 7'b1001111);
    end

    // Out-of-range codes show a dash
    @(negedge clk); set_code(4'b1010); tick;
    check("dash_10", seg_cc, 7'b0000001);
    @(negedge clk); set_code(4'b1100); tick;
    check("dash_12", seg_cc, 7'b0000001);
    @(negedge clk); set_code(4'b1111); tick;
    check("dash_15", seg_cc, 7'b0000001);
    check("ca_dash_15", seg_ca, 7'b1111110);

    // Only the value at the edge matters
    @(negedge clk); set_code(4'b0011); tick;
    check("latency_3", seg_cc, 7'b1111001);
    #3 set_code(4'b0100);
    #1 check("hold_3", seg_cc, 7'b1111001);
    tick;
    check("latency_4", seg_cc, 7'b0110011);

    // Short reset pulse between edges while showing 8
    @(negedge clk); set_code(4'd8); tick;
    check("pre_pulse_8", seg_cc, 7'b1111111);
    #2 rst_n = 1'b0;
    #1 check_off("pulse_low");
    #1 rst_n = 1'b1;
    #1 check_off("pulse_released");
    tick;
    check_both("after_pulse", 8);

    // Randomized codes with junk driven between edges and occasional resets
    for (int i = 0; i < 300; i++) begin
      int n;
      n = int'($urandom_range(0, 15));
      @(negedge clk);
      set_code(4'(n));
      tick;
      check_both("rand", n);
      #1 set_code(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        #1 check_off("rand_reset");
        rst_n = 1'b1;
        #1 check_off("rand_reset_rel");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
